mem_access: RTL and testbench

Memory-access stage of the RV32I pipeline, sitting between execute and the register-file write port. It accepts one instruction at a time from execute, then either passes an ALU result through or performs a load or store. Loads and stores go over a byte-wide, one-cycle-latency memory port, one byte per cycle, in little-endian order. Its registered `w_addr`/`w_data`/`we` outputs drive the register-file write port directly.

---
 rtl/mem_access_pkg.sv | 43 ++++
 rtl/mem_load_ext.sv | 34 +++
 rtl/mem_access.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants for the mem_access stage: register-file widths, mem_op
// and funct3 encodings, FSM state type and small decode helpers.
package mem_access_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_e;

    // Number of bytes moved for a funct3 code; reserved codes behave as W.
    function automatic logic [2:0] width_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: width_bytes = 3'd1;
            F3_H, F3_HU: width_bytes = 3'd2;
            F3_W:        width_bytes = 3'd4;
            default:     width_bytes = 3'd4;
        endcase
    endfunction

    // Halfwords need bit 0 clear, words need bits 1:0 clear.
    function automatic logic is_misaligned(input logic [2:0] nbytes, input logic [1:0] addr_lo);
        case (nbytes)
            3'd2:    is_misaligned = addr_lo[0];
            3'd4:    is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result extension: takes the little-endian assembled bytes and widens
// byte/halfword loads with sign (B/H) or zero (BU/HU) fill.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    input  logic [2:0]  nbytes,
    output logic [31:0] result
);

    // Select fill pattern from the access width and signedness
    always_comb begin
        result = raw;
        case (nbytes)
            3'd1: begin
                if (funct3 == F3_B) begin
                    result = {{24{raw[7]}}, raw[7:0]};
                end else begin
                    result = {24'd0, raw[7:0]};
                end
            end
            3'd2: begin
                if (funct3 == F3_H) begin
                    result = {{16{raw[15]}}, raw[15:0]};
                end else begin
                    result = {16'd0, raw[15:0]};
                end
            end
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage. ALU results pass straight to the register-file
// write port; loads and stores move one byte per cycle over a byte-wide,
// one-cycle-latency memory port in little-endian order.
// Optional feature: define MEM_MISALIGN_CHK_EN to trap misaligned H/W
// accesses (pulse on misalign, no memory traffic, no write-back).
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [1:0]            ex_mem_op,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [31:0]           ex_sdata,
    input  logic                  ex_wreg,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_W-1:0]      ex_alu,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [REG_W-1:0]      w_data,
    output logic                  we,
    output logic                  misalign
);

    state_e                state_r, state_s;
    logic [2:0]            cnt_r, cnt_s;
    logic [2:0]            n_r, n_s;
    logic [ADDR_W-1:0]     base_r, base_s;
    logic [31:0]           sdata_r, sdata_s;
    logic [2:0]            funct3_r, funct3_s;
    logic [REG_ADDR_W-1:0] rd_r, rd_s;
    logic                  wreg_r, wreg_s;
    logic [31:0]           data_r, data_s;
    logic [REG_ADDR_W-1:0] w_addr_r, w_addr_s;
    logic [REG_W-1:0]      w_data_r, w_data_s;
    logic                  we_r, we_s;
    logic                  misalign_r, misalign_s;
    logic [ADDR_W-1:0]     mem_a_r, mem_a_s;
    logic                  mem_wr_r, mem_wr_s;
    logic [7:0]            mem_dout_r, mem_dout_s;
    logic [31:0]           asm_s;
    logic [31:0]           ext_s;
    logic                  mis_s;

`ifdef MEM_MISALIGN_CHK_EN
    assign mis_s = ((ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE)) &&
                   is_misaligned(width_bytes(ex_funct3), ex_addr[1:0]);
`else
    assign mis_s = 1'b0;
`endif

    // Merge the byte arriving this cycle into lane cnt-1 of the load buffer
    always_comb begin
        case (cnt_r)
            3'd1:    asm_s = {data_r[31:8], mem_din};
            3'd2:    asm_s = {data_r[31:16], mem_din, data_r[7:0]};
            3'd3:    asm_s = {data_r[31:24], mem_din, data_r[15:0]};
            3'd4:    asm_s = {mem_din, data_r[23:0]};
            default: asm_s = data_r;
        endcase
    end

    mem_load_ext u_ext (
        .raw    (asm_s),
        .funct3 (funct3_r),
        .nbytes (n_r),
        .result (ext_s)
    );

    // Next-state logic: accept in IDLE, step the byte counter, retire loads
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        n_s        = n_r;
        base_s     = base_r;
        sdata_s    = sdata_r;
        funct3_s   = funct3_r;
        rd_s       = rd_r;
        wreg_s     = wreg_r;
        data_s     = data_r;
        w_addr_s   = w_addr_r;
        w_data_s   = w_data_r;
        we_s       = 1'b0;
        misalign_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 3'd0;
                if (ex_valid) begin
                    base_s   = ex_addr;
                    sdata_s  = ex_sdata;
                    funct3_s = ex_funct3;
                    n_s      = width_bytes(ex_funct3);
                    rd_s     = ex_rd;
                    wreg_s   = ex_wreg;
                    data_s   = 32'd0;
                    if (mis_s) begin
                        misalign_s = 1'b1;
                    end else begin
                        case (ex_mem_op)
                            MEM_LOAD:  state_s = ST_LOAD;
                            MEM_STORE: state_s = ST_STORE;
                            MEM_NONE: begin
                                w_addr_s = ex_rd;
                                w_data_s = ex_alu;
                                we_s     = ex_wreg;
                            end
                            default: begin
                                w_addr_s = ex_rd;
                                w_data_s = ex_alu;
                                we_s     = ex_wreg;
                            end
                        endcase
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_s = cnt_r + 3'd1;
                if (cnt_r != 3'd0) begin
                    data_s = asm_s;
                end else begin
                    data_s = data_r;
                end
                if (cnt_r == n_r) begin
                    state_s  = ST_IDLE;
                    cnt_s    = 3'd0;
                    we_s     = wreg_r;
                    w_addr_s = rd_r;
                    w_data_s = ext_s;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_STORE: begin
                if (cnt_r == (n_r - 3'd1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // Memory-port values for the coming cycle, derived from the next state
    always_comb begin
        mem_a_s    = {ADDR_W{1'b0}};
        mem_wr_s   = 1'b0;
        mem_dout_s = 8'd0;
        if (((state_s == ST_LOAD) || (state_s == ST_STORE)) && (cnt_s < n_s)) begin
            mem_a_s = base_s + ADDR_W'(cnt_s);
            if (state_s == ST_STORE) begin
                mem_wr_s = 1'b1;
                case (cnt_s[1:0])
                    2'd0:    mem_dout_s = sdata_s[7:0];
                    2'd1:    mem_dout_s = sdata_s[15:8];
                    2'd2:    mem_dout_s = sdata_s[23:16];
                    default: mem_dout_s = sdata_s[31:24];
                endcase
            end else begin
                mem_wr_s = 1'b0;
            end
        end else begin
            mem_a_s = {ADDR_W{1'b0}};
        end
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            n_r        <= 3'd0;
            base_r     <= {ADDR_W{1'b0}};
            sdata_r    <= 32'd0;
            funct3_r   <= 3'd0;
            rd_r       <= {REG_ADDR_W{1'b0}};
            wreg_r     <= 1'b0;
            data_r     <= 32'd0;
            w_addr_r   <= {REG_ADDR_W{1'b0}};
            w_data_r   <= {REG_W{1'b0}};
            we_r       <= 1'b0;
            misalign_r <= 1'b0;
            mem_a_r    <= {ADDR_W{1'b0}};
            mem_wr_r   <= 1'b0;
            mem_dout_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            n_r        <= n_s;
            base_r     <= base_s;
            sdata_r    <= sdata_s;
            funct3_r   <= funct3_s;
            rd_r       <= rd_s;
            wreg_r     <= wreg_s;
            data_r     <= data_s;
            w_addr_r   <= w_addr_s;
            w_data_r   <= w_data_s;
            we_r       <= we_s;
            misalign_r <= misalign_s;
            mem_a_r    <= mem_a_s;
            mem_wr_r   <= mem_wr_s;
            mem_dout_r <= mem_dout_s;
        end
    end

    assign ex_ready = (state_r == ST_IDLE);
    assign mem_a    = mem_a_r;
    assign mem_wr   = mem_wr_r;
    assign mem_dout = mem_dout_r;
    assign w_addr   = w_addr_r;
    assign w_data   = w_data_r;
    assign we       = we_r;
    assign misalign = misalign_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a table of directed vectors, a few
// hand-written multi-cycle sequences (back-to-back, reset mid-load, wrap,
// misalignment) and randomized traffic checked against a byte-array model.
module tb_mem_access;

`ifdef MEM_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_mem_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic        ex_wreg;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        we;
    logic        misalign;

    int passed = 0;
    int total  = 0;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_sdata(ex_sdata), .ex_wreg(ex_wreg), .ex_rd(ex_rd), .ex_alu(ex_alu),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .w_addr(w_addr), .w_data(w_data), .we(we), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: 4 KiB aliased on addr[11:0], one-cycle read latency
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        mem_init;
    logic        pl_en;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;

    function automatic logic [7:0] pat(input int i);
        pat = 8'((i * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else begin
            if (pl_en) mem[pl_a] <= pl_d;
            if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= mem[mem_a[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        pl_a = a; pl_d = d; pl_en = 1'b1;
        @(posedge clk); @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one instruction at a negedge and check every following cycle
    // against the model; returns at the negedge of the retire/ready cycle.
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input logic wreg,
                         input logic [31:0] alu, output logic [31:0] got_wdata, output int got_we_cyc);
        int n; int lat; bit mis; bit is_ld; bit is_st; bit retire;
        logic [31:0] raw; logic [31:0] expv; logic [31:0] a;
        n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
        is_ld = (op == 2'b01);
        is_st = (op == 2'b10);
        mis = MIS_EN && (is_ld || is_st) && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
        raw = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            raw = raw + (32'(ref_mem[a[11:0]]) << (8 * i));
        end
        expv = raw;
        if (n == 1 && f3 == 3'd0 && raw >= 32'd128) expv = raw - 32'd256;
        if (n == 2 && f3 == 3'd1 && raw >= 32'h8000) expv = raw - 32'h10000;
        if (!is_ld && !is_st) expv = alu;
        retire = !mis && !is_st;
        lat = mis ? 1 : (is_ld ? n + 2 : (is_st ? n + 1 : 1));
        if (is_st && !mis) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                ref_mem[a[11:0]] = 8'((sdata >> (8 * i)) & 32'hFF);
            end
        end
        chk("ready_pre", {31'd0, ex_ready}, 32'd1);
        ex_valid = 1'b1; ex_mem_op = op; ex_funct3 = f3; ex_addr = addr;
        ex_sdata = sdata; ex_rd = rd; ex_wreg = wreg; ex_alu = alu;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        got_we_cyc = 0;
        got_wdata = 32'd0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            if (we === 1'b1 && got_we_cyc == 0) got_we_cyc = c;
            chk("we", {31'd0, we}, (retire && c == lat) ? {31'd0, wreg} : 32'd0);
            chk("ex_ready", {31'd0, ex_ready}, (c == lat) ? 32'd1 : 32'd0);
            chk("misalign", {31'd0, misalign}, (mis && c == 1) ? 32'd1 : 32'd0);
            if (retire && c == lat) begin
                chk("w_addr", {27'd0, w_addr}, {27'd0, rd});
                chk("w_data", w_data, expv);
                got_wdata = w_data;
            end
            if (!mis && (is_ld || is_st) && c <= n) begin
                a = addr + 32'(c - 1);
                chk("mem_a", mem_a, a);
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, is_st});
                if (is_st) chk("mem_dout", {24'd0, mem_dout}, (sdata >> (8 * (c - 1))) & 32'hFF);
            end else if (c == lat) begin
                chk("mem_a_idle", mem_a, 32'd0);
                chk("mem_wr_idle", {31'd0, mem_wr}, 32'd0);
                chk("mem_dout_idle", {24'd0, mem_dout}, 32'd0);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] alu;
        logic [31:0] exp_data;
        int          exp_we_cyc;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] gw;
    int          gc;
    logic [1:0]  r_op;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    initial begin
        vecs[0]  = '{2'b01, 3'b000, 32'h100, 32'h0,        5'd3,  1'b1, 32'h0,        32'hFFFFFF80, 3};
        vecs[1]  = '{2'b01, 3'b100, 32'h100, 32'h0,        5'd4,  1'b1, 32'h0,        32'h00000080, 3};
        vecs[2]  = '{2'b01, 3'b010, 32'h200, 32'h0,        5'd9,  1'b1, 32'h0,        32'h44332211, 6};
        vecs[3]  = '{2'b01, 3'b001, 32'h202, 32'h0,        5'd10, 1'b1, 32'h0,        32'h00004433, 4};
        vecs[4]  = '{2'b01, 3'b001, 32'h204, 32'h0,        5'd11, 1'b1, 32'h0,        32'hFFFF9000, 4};
        vecs[5]  = '{2'b01, 3'b101, 32'h204, 32'h0,        5'd12, 1'b1, 32'h0,        32'h00009000, 4};
        vecs[6]  = '{2'b01, 3'b011, 32'h200, 32'h0,        5'd13, 1'b1, 32'h0,        32'h44332211, 6};
        vecs[7]  = '{2'b00, 3'b000, 32'h0,   32'h0,        5'd5,  1'b1, 32'h12345678, 32'h12345678, 1};
        vecs[8]  = '{2'b11, 3'b000, 32'h0,   32'h0,        5'd8,  1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1};
        vecs[9]  = '{2'b10, 3'b001, 32'h300, 32'hABCD1234, 5'd2,  1'b1, 32'h0,        32'h0,        0};
        vecs[10] = '{2'b01, 3'b010, 32'h300, 32'h0,        5'd14, 1'b1, 32'h0,        32'h00001234, 6};
        vecs[11] = '{2'b00, 3'b000, 32'h0,   32'h0,        5'd1,  1'b0, 32'h55555555, 32'h0,        0};

        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        rst = 1'b0; ex_valid = 1'b0; ex_mem_op = 2'b00; ex_funct3 = 3'b000; ex_addr = 32'd0;
        ex_sdata = 32'd0; ex_wreg = 1'b0; ex_rd = 5'd0; ex_alu = 32'd0;
        mem_init = 1'b1; pl_en = 1'b0; pl_a = 12'd0; pl_d = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        preload(12'h100, 8'h80); preload(12'h104, 8'h7F);
        preload(12'h200, 8'h11); preload(12'h201, 8'h22);
        preload(12'h202, 8'h33); preload(12'h203, 8'h44);
        preload(12'h204, 8'h00); preload(12'h205, 8'h90);
        preload(12'h302, 8'h00); preload(12'h303, 8'h00);

        // Reset state
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].sdata, vecs[i].rd,
                  vecs[i].wreg, vecs[i].alu, gw, gc);
            chk("tbl_we_cycle", 32'(gc), 32'(vecs[i].exp_we_cyc));
            if (vecs[i].exp_we_cyc != 0) chk("tbl_w_data", gw, vecs[i].exp_data);
        end

        // Back-to-back ALU ops: each accepted in the previous one's we cycle
        do_op(2'b00, 3'd0, 32'd0, 32'd0, 5'd5, 1'b1, 32'h00000005, gw, gc);
        do_op(2'b00, 3'd0, 32'd0, 32'd0, 5'd6, 1'b1, 32'h00000006, gw, gc);
        do_op(2'b00, 3'd0, 32'd0, 32'd0, 5'd7, 1'b1, 32'h00000007, gw, gc);
        do_op(2'b00, 3'd0, 32'd0, 32'd0, 5'd8, 1'b0, 32'h00000008, gw, gc);

        // Reset in the middle of an LW (cnt = 2)
        do_op(2'b00, 3'd0, 32'd0, 32'd0, 5'd9, 1'b1, 32'h0BADF00D, gw, gc);
        ex_valid = 1'b1; ex_mem_op = 2'b01; ex_funct3 = 3'b010; ex_addr = 32'h200;
        ex_rd = 5'd15; ex_wreg = 1'b1;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("rst_mid_mem_a_pre", mem_a, 32'h202);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_we", {31'd0, we}, 32'd0);
        chk("rst_mid_mem_a", mem_a, 32'd0);
        chk("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mid_w_data", w_data, 32'd0);
        rst = 1'b1;
        do_op(2'b01, 3'b000, 32'h104, 32'd0, 5'd16, 1'b1, 32'd0, gw, gc);
        chk("rst_mid_lb_after", gw, 32'h0000007F);
        chk("rst_mid_lb_lat", 32'(gc), 32'd3);

        // Misaligned word and address wrap-around
        do_op(2'b01, 3'b010, 32'h102, 32'd0, 5'd17, 1'b1, 32'd0, gw, gc);
        do_op(2'b10, 3'b010, 32'hFFFFFFFE, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0, gw, gc);
        do_op(2'b01, 3'b010, 32'hFFFFFFFE, 32'd0, 5'd18, 1'b1, 32'd0, gw, gc);
        do_op(2'b01, 3'b101, 32'hFFFFFFFF, 32'd0, 5'd19, 1'b1, 32'd0, gw, gc);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ex_valid = 1'b0;
                @(posedge clk); @(negedge clk);
                chk("gap_we", {31'd0, we}, 32'd0);
            end
            r_op = 2'($urandom_range(0, 3));
            r_f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       r_addr = 32'h400 + 32'($urandom_range(0, 63));
                1:       r_addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
                default: r_addr = 32'h0 + 32'($urandom_range(0, 15));
            endcase
            do_op(r_op, r_f3, r_addr, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom, gw, gc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
